// File: rtl/wb_pkg.sv
// wb_pkg -- shared types and defaults for the writeback arbiter.
//   wb_req_t      : one register-file write request (index + data)
//   WB_DEPTH      : default long-latency queue depth
//   WB_STARVE_MAX : default number of consecutive ALU wins tolerated
//   idx_onehot()  : register index -> one-hot mask, index 0 maps to no bit
package wb_pkg;

   localparam int WB_DEPTH      = 4;
   localparam int WB_STARVE_MAX = 7;

   typedef struct packed {
      logic [4:0]  index;
      logic [31:0] data;
   } wb_req_t;

   // Register 0 is hard-wired, so it never contributes a pending bit.
   function automatic logic [31:0] idx_onehot(input logic [4:0] idx);
      logic [31:0] m;
      m = 32'd0;
      if (idx != 5'd0) begin
         m[idx] = 1'b1;
      end else begin
         m = 32'd0;
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- in-order queue of long-latency writeback requests.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   push_i/push_req_i: enqueue one request (ignored when full)
//   pop_i / head_o   : dequeue the oldest request (ignored when empty)
//   count_o          : occupancy, 0..DEPTH
//   full_o, empty_o  : occupancy flags
//   vld_o, idx_o     : per-slot occupancy and destination index
// A pushed entry is only visible at head_o from the next cycle, so a push
// into an empty queue can never be popped in the same cycle.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  wb_req_t                      push_req_i,
   input  logic                         pop_i,
   output wb_req_t                      head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [DEPTH-1:0]             vld_o,
   output logic [DEPTH-1:0][4:0]        idx_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   wb_req_t           mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic              do_push_s, do_pop_s;

   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == {CW{1'b0}});
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign head_o    = mem_q[rptr_q];
   assign count_o   = count_q;
   assign vld_o     = vld_q;

   // Expose each slot's destination index for the pending mask.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         idx_o[i] = mem_q[i].index;
      end
   end

   // Next pointer, occupancy and slot-valid state.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      vld_d   = vld_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_pop_s) begin
         rptr_d        = rptr_q + 1'b1;
         vld_d[rptr_q] = 1'b0;
      end else begin
         rptr_d = rptr_q;
      end
      if (do_push_s) begin
         wptr_d        = wptr_q + 1'b1;
         vld_d[wptr_q] = 1'b1;
      end else begin
         wptr_d = wptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Queue state registers; storage is cleared so no stale data survives reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= {PW{1'b0}};
         rptr_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
         vld_q   <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '{index: 5'd0, data: 32'd0};
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         vld_q   <= vld_d;
         if (do_push_s) begin
            mem_q[wptr_q] <= push_req_i;
         end
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter -- merges single-cycle ALU results and queued
// long-latency results onto one register-file write port.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   alu_valid/alu_index/alu_data    : ALU result; held upstream while alu_stall
//   alu_stall                       : ALU refused this cycle
//   lng_valid/lng_ready/lng_index/lng_data : long-latency valid/ready push
//   write_enable/write_index3/write_data3  : registered register-file write
//   pending_mask                    : bit i set while register i is queued
//   fifo_count                      : queue occupancy
//   fwd_index/fwd_hit/fwd_data      : write-port forwarding, only when the
//                                     WB_FWD_EN macro is defined
// ALU has priority unless it has starved a non-empty queue for STARVE_MAX
// consecutive cycles. Index 0 requests are dropped.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH      = WB_DEPTH,
   parameter int STARVE_MAX = WB_STARVE_MAX
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         alu_valid,
   input  logic [4:0]                   alu_index,
   input  logic [31:0]                  alu_data,
   output logic                         alu_stall,
   input  logic                         lng_valid,
   output logic                         lng_ready,
   input  logic [4:0]                   lng_index,
   input  logic [31:0]                  lng_data,
   output logic                         write_enable,
   output logic [4:0]                   write_index3,
   output logic [31:0]                  write_data3,
`ifdef WB_FWD_EN
   input  logic [4:0]                   fwd_index,
   output logic                         fwd_hit,
   output logic [31:0]                  fwd_data,
`endif
   output logic [31:0]                  pending_mask,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int SW = $clog2(STARVE_MAX+1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic                     live_q;
   logic [SW-1:0]            starve_q, starve_d;
   logic                     we_q, we_d;
   logic [4:0]               widx_q, widx_d;
   logic [31:0]              wdata_q, wdata_d;

   wb_req_t                  head_s, push_req_s;
   logic                     full_s, empty_s;
   logic                     push_s, pop_s, alu_req_s, alu_win_s;
   logic                     stall_s;
   logic [DEPTH-1:0]         vld_s;
   logic [DEPTH-1:0][4:0]    idx_s;
   logic [31:0]              pend_s;

   // live_q stays low until the first edge after reset: the port is closed
   // for that cycle so nothing is written or pushed on that edge.
   assign stall_s    = reset && (!live_q || ((starve_q == STARVE_LIM) && !empty_s));
   assign alu_stall  = stall_s;
   assign lng_ready  = live_q && !full_s;
   assign alu_req_s  = alu_valid && (alu_index != 5'd0);
   assign alu_win_s  = alu_req_s && !stall_s;
   assign pop_s      = live_q && !empty_s && (stall_s || !alu_req_s);
   assign push_s     = lng_valid && lng_ready && (lng_index != 5'd0);
   assign push_req_s = '{index: lng_index, data: lng_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .push_i     (push_s),
      .push_req_i (push_req_s),
      .pop_i      (pop_s),
      .head_o     (head_s),
      .count_o    (fifo_count),
      .full_o     (full_s),
      .empty_o    (empty_s),
      .vld_o      (vld_s),
      .idx_o      (idx_s)
   );

   // Pending mask: OR of the one-hot destinations of every occupied slot.
   always_comb begin
      pend_s = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_s[i]) begin
            pend_s = pend_s | idx_onehot(idx_s[i]);
         end else begin
            pend_s = pend_s;
         end
      end
   end
   assign pending_mask = pend_s;

   // Winner selection and starvation tracking.
   always_comb begin
      we_d     = 1'b0;
      widx_d   = widx_q;
      wdata_d  = wdata_q;
      starve_d = starve_q;
      if (pop_s) begin
         we_d     = 1'b1;
         widx_d   = head_s.index;
         wdata_d  = head_s.data;
         starve_d = {SW{1'b0}};
      end else if (alu_win_s) begin
         we_d    = 1'b1;
         widx_d  = alu_index;
         wdata_d = alu_data;
         // Saturation is unnecessary: reaching STARVE_LIM forces a pop.
         if (empty_s) begin
            starve_d = {SW{1'b0}};
         end else begin
            starve_d = starve_q + 1'b1;
         end
      end else begin
         we_d     = 1'b0;
         starve_d = {SW{1'b0}};
      end
   end

   // Registered write port and arbitration state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         live_q   <= 1'b0;
         starve_q <= {SW{1'b0}};
         we_q     <= 1'b0;
         widx_q   <= 5'd0;
         wdata_q  <= 32'd0;
      end else begin
         live_q   <= 1'b1;
         starve_q <= starve_d;
         we_q     <= we_d;
         widx_q   <= widx_d;
         wdata_q  <= wdata_d;
      end
   end

   assign write_enable = we_q;
   assign write_index3 = widx_q;
   assign write_data3  = wdata_q;

`ifdef WB_FWD_EN
   assign fwd_hit  = we_q && (widx_q == fwd_index) && (fwd_index != 5'd0);
   assign fwd_data = fwd_hit ? wdata_q : 32'd0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
   import wb_pkg::*;

   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 7;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_index;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        lng_valid;
   logic        lng_ready;
   logic [4:0]  lng_index;
   logic [31:0] lng_data;
   logic        write_enable;
   logic [4:0]  write_index3;
   logic [31:0] write_data3;
   logic [31:0] pending_mask;
   logic [2:0]  fifo_count;

   writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_index    (alu_index),
      .alu_data     (alu_data),
      .alu_stall    (alu_stall),
      .lng_valid    (lng_valid),
      .lng_ready    (lng_ready),
      .lng_index    (lng_index),
      .lng_data     (lng_data),
      .write_enable (write_enable),
      .write_index3 (write_index3),
      .write_data3  (write_data3),
      .pending_mask (pending_mask),
      .fifo_count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model: queue contents, starvation count, expected write.
   wb_req_t     mq[$];
   int          m_starve;
   bit          m_live;
   bit          m_we;
   logic [4:0]  m_idx;
   logic [31:0] m_data;
   logic        samp_stall;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, check combinational outputs, advance model,
   // check registered outputs after the edge, return at the next negedge.
   task automatic step(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [4:0] li, input logic [31:0] ld);
      bit          exp_stall, exp_ready, had, alu_req;
      logic [31:0] pm;
      wb_req_t     h;
      alu_valid = av; alu_index = ai; alu_data = ad;
      lng_valid = lv; lng_index = li; lng_data = ld;
      #1;
      exp_ready = m_live && (mq.size() < DEPTH);
      exp_stall = !m_live || ((m_starve == STARVE_MAX) && (mq.size() != 0));
      pm = 32'd0;
      foreach (mq[k]) pm = pm | (32'd1 << mq[k].index);
      chk("alu_stall", {31'd0, alu_stall}, {31'd0, exp_stall});
      chk("lng_ready", {31'd0, lng_ready}, {31'd0, exp_ready});
      chk("pending_mask", pending_mask, pm);
      chk("fifo_count", {29'd0, fifo_count}, 32'(mq.size()));
      samp_stall = alu_stall;
      had     = (mq.size() != 0);
      alu_req = av && (ai != 5'd0);
      if (!m_live) begin
         m_we = 1'b0;
      end else if (had && (exp_stall || !alu_req)) begin
         h = mq.pop_front();
         m_we = 1'b1; m_idx = h.index; m_data = h.data;
         m_starve = 0;
      end else if (alu_req) begin
         m_we = 1'b1; m_idx = ai; m_data = ad;
         m_starve = had ? m_starve + 1 : 0;
      end else begin
         m_we = 1'b0;
         m_starve = 0;
      end
      if (lv && exp_ready && (li != 5'd0)) mq.push_back('{index: li, data: ld});
      m_live = 1'b1;
      @(posedge clk);
      #1;
      chk("write_enable", {31'd0, write_enable}, {31'd0, m_we});
      if (m_we) begin
         chk("write_index3", {27'd0, write_index3}, {27'd0, m_idx});
         chk("write_data3", write_data3, m_data);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we"},    {31'd0, write_enable}, 32'd0);
      chk({tag, "_widx"},  {27'd0, write_index3}, 32'd0);
      chk({tag, "_wdata"}, write_data3, 32'd0);
      chk({tag, "_pend"},  pending_mask, 32'd0);
      chk({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
      chk({tag, "_stall"}, {31'd0, alu_stall}, 32'd0);
      chk({tag, "_ready"}, {31'd0, lng_ready}, 32'd0);
   endtask

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      m_live   = 1'b0;
      m_we     = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      alu_valid = 1'b0; alu_index = 5'd0; alu_data = 32'd0;
      lng_valid = 1'b0; lng_index = 5'd0; lng_data = 32'd0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("por");
      @(negedge clk);
      reset = 1'b1;

      // First edge after release: no write, lng_ready rises.
      step(1'b1, 5'd2, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      chk("ready_rise", {31'd0, lng_ready}, 32'd1);
      chk("first_edge_no_we", {31'd0, write_enable}, 32'd0);

      // ALU-only write.
      step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
      chk("alu_we", {31'd0, write_enable}, 32'd1);
      chk("alu_idx", {27'd0, write_index3}, 32'd5);
      chk("alu_data", write_data3, 32'h1234);

      // Collision: ALU first, long-latency request pends then drains.
      step(1'b1, 5'd3, 32'h0000AAAA, 1'b1, 5'd9, 32'h00009999);
      chk("coll_alu_idx", {27'd0, write_index3}, 32'd3);
      chk("coll_pend", pending_mask, 32'h200);
      idle();
      chk("coll_lng_idx", {27'd0, write_index3}, 32'd9);
      chk("coll_lng_data", write_data3, 32'h00009999);
      chk("coll_pend_clr", pending_mask, 32'h0);

      // Fill the queue while the ALU keeps winning.
      for (int i = 1; i <= 4; i++)
         step(1'b1, 5'(10 + i), 32'(32'h100 + i), 1'b1, 5'(i), 32'(32'hA0 + i));
      chk("full_count", {29'd0, fifo_count}, 32'd4);
      chk("full_ready", {31'd0, lng_ready}, 32'd0);
      chk("full_pend", pending_mask, 32'h1E);
      // Fifth request offered but refused; ALU starves the queue further.
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'(15 + i), 32'(32'h200 + i), 1'b1, 5'd6, 32'h66);
      chk("full_hold", {29'd0, fifo_count}, 32'd4);

      // Eighth non-empty cycle: queue head forced through.
      step(1'b1, 5'd20, 32'h2020, 1'b1, 5'd6, 32'h66);
      chk("starve_stall", {31'd0, samp_stall}, 32'd1);
      chk("starve_head", {27'd0, write_index3}, 32'd1);
      chk("starve_head_d", write_data3, 32'hA1);
      step(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'd0);
      chk("starve_alu", {27'd0, write_index3}, 32'd20);
      chk("starve_alu_d", write_data3, 32'h2020);
      repeat (4) idle();

      // Index 0 requests are dropped.
      step(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0);
      chk("idx0_alu", {31'd0, write_enable}, 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
      chk("idx0_lng", {29'd0, fifo_count}, 32'd0);

      // Same index queued twice: written in order; push into empty waits a cycle.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA);
      chk("dup_nobypass", {31'd0, write_enable}, 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB);
      chk("dup_first", write_data3, 32'hA);
      chk("dup_pend", pending_mask, 32'h80);
      chk("dup_count", {29'd0, fifo_count}, 32'd1);
      idle();
      chk("dup_second", write_data3, 32'hB);
      idle();

      // Mixed traffic with small index range to exercise duplicates and wrap.
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      repeat (DEPTH + 1) idle();

      // Reset with three entries queued.
      for (int i = 0; i < 3; i++)
         step(1'b1, 5'(21 + i), 32'(32'h300 + i), 1'b1, 5'(8 + i), 32'(32'h800 + i));
      chk("rst_pre_count", {29'd0, fifo_count}, 32'd3);
      #3;
      reset = 1'b0;
      #1;
      chk_reset_outputs("mid");
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      step(1'b1, 5'd10, 32'h77, 1'b0, 5'd0, 32'd0);
      chk("post_rst_no_we", {31'd0, write_enable}, 32'd0);
      chk("post_rst_count", {29'd0, fifo_count}, 32'd0);
      step(1'b1, 5'd10, 32'h77, 1'b0, 5'd0, 32'd0);
      chk("post_rst_alu", {27'd0, write_index3}, 32'd10);
      idle();
      chk("post_rst_stale", {31'd0, write_enable}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning long-latency queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter STARVE_MAX, default 7, meaning consecutive ALU wins tolerated while the queue is non-empty.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports, one per line:
 clk  in  1  clock
 reset  in  1  asynchronous, active-low
 alu_valid  in  1  single-cycle ALU result present
 alu_index  in  5  ALU destination register
 alu_data  in  32  ALU result
 alu_stall  out  1  ALU result refused this cycle; upstream holds it
 lng_valid  in  1  long-latency result (load/mult/div) present
 lng_ready  out  1  queue can accept
 lng_index  in  5  long-latency destination register
 lng_data  in  32  long-latency result
 write_enable  out  1  register-file write strobe
 write_index3  out  5  register-file write index
 write_data3  out  32  register-file write data
 pending_mask  out  32  bit i set while register i is queued
 fifo_count  out  $clog2(DEPTH+1)  queue occupancy

Function
REQ-005 write_enable, write_index3 and write_data3 SHALL be registered; a winning request appears one clk edge after acceptance.
REQ-006 lng handshake SHALL occur when lng_valid && lng_ready; lng_ready SHALL be (fifo_count < DEPTH), independent of lng_valid.
REQ-007 Accepted long-latency requests SHALL enter the queue in order; the queue SHALL NOT bypass.
REQ-008 Per cycle, arbitration SHALL be: if alu_stall, pop queue head; else if alu_valid, write ALU request; else if queue non-empty, pop queue head; else write_enable=0 next edge.
REQ-009 Push and pop in the same cycle SHALL leave fifo_count unchanged; a request pushed into an empty queue SHALL be poppable no earlier than the next cycle.
REQ-010 Requests with index 0 SHALL be discarded: ALU index-0 produces no write; lng index-0 handshakes normally but is not queued.
REQ-011 Starvation counter SHALL increment on each cycle where ALU wins while the queue is non-empty, and clear on any pop or when the queue is empty.
REQ-012 alu_stall SHALL be asserted combinationally when the counter equals STARVE_MAX and the queue is non-empty; that cycle the queue head SHALL win regardless of alu_valid.
REQ-013 pending_mask SHALL be the OR of one-hot indices of all queue entries, bit 0 always 0, updated with the queue state.
REQ-014 Multiple queued entries to the same index SHALL all be written in order (last write wins in the register file).
REQ-015 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH nor underflow.

Reset
REQ-016 While reset is 0: write_enable=0, write_index3=0, write_data3=0, pending_mask=0, fifo_count=0, alu_stall=0, lng_ready=0, starvation counter=0.
REQ-017 Reset asserted mid-operation SHALL discard all queued entries; no write SHALL occur on the first edge after release.
REQ-018 lng_ready SHALL rise on the first clk edge after reset deasserts.

Configuration
REQ-019 With WB_FWD_EN defined, ports fwd_index (in 5), fwd_hit (out 1), fwd_data (out 32) SHALL exist; fwd_hit = write_enable && write_index3==fwd_index && fwd_index!=0, fwd_data = write_data3 when hit else 0, combinational.
REQ-020 Without WB_FWD_EN, those ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-021 Package wb_pkg SHALL hold typedef wb_req_t {index[4:0], data[31:0]} and default constants WB_DEPTH=4, WB_STARVE_MAX=7.
REQ-022 The queue SHALL be sub-module wb_fifo (wb_req_t entries, push/pop, count, full/empty, per-entry index visibility for pending_mask).

Verification
REQ-023 ALU only: alu_valid, index 5, data 0x1234 -> next edge write_enable=1, write_index3=5, write_data3=0x1234.
REQ-024 Collision: alu index 3 and lng index 9 same cycle -> ALU written first, pending_mask=0x200, next idle cycle writes 9, pending_mask=0.
REQ-025 Full: 4 lng pushes with alu_valid held -> fifo_count=4, lng_ready=0; fifth lng_valid not accepted.
REQ-026 Starvation: queue non-empty, alu_valid continuous -> alu_stall=1 on 8th cycle, queue head written, counter cleared, held ALU written next cycle.
REQ-027 Index 0: ALU index 0 -> write_enable stays 0; lng index 0 -> handshakes, fifo_count unchanged.
REQ-028 Reset with fifo_count=3 -> all outputs 0 immediately, fifo_count=0 after release, no stale writes.
